seg7_bcd_scan: RTL and testbench
================================

# seg7_bcd_scan

Parametrised multi-digit 7-segment display driver for the calculator datapath. The block accepts an unsigned binary result on a load strobe, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and latches the digits into a display register. It then time-multiplexes the digits onto one shared segment bus. It replaces the fixed three-digit combinational number-to-segment converter and adds overflow indication, a load/busy handshake and digit scanning.

## Interface
- DIGITS, 4: number of displayed decimal digits (1..8)
- DATA_W, 14: input binary width (1..27)
- SCAN_DIV, 50000: clock cycles per digit scan slot (≥2)

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-low
- load  in  1  sample data and start conversion; accepted only when busy=0
- data  in  DATA_W  unsigned binary value to display
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when the display register is updated
- ovf  out  1  last committed value exceeded 10^DIGITS−1
- seg  out  8  segment code {a,b,c,d,e,f,g,dp}, active-high, dp always 0
- an  out  DIGITS  one-hot digit enable, active-high, bit 0 = least-significant digit

## Operation
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: when load=1, capture data into shift register, clear the BCD register and the overflow accumulator, set iteration count to 0, and go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shift} left by 1. Any 1 shifted out of the top nibble sets the overflow accumulator (sticky). After DATA_W iterations, go to COMMIT.
  - COMMIT: copy the BCD register to the display register and the accumulator to ovf, pulse done, then go to IDLE.
- load while busy=1 is ignored; there is no queueing.
- Overflow display: when ovf=1, every digit shows "-" (seg=8'h02), regardless of the display register.
- Segment map: 0→FC, 1→60, 2→DA, 3→F2, 4→66, 5→B6, 6→BE, 7→E0, 8→FE, 9→F6. Any nibble >9 maps to 00; this is unreachable in normal use.
- Scan logic:
  - A prescaler counts 0..SCAN_DIV−1 and wraps.
  - On each wrap, the digit index advances 0→1→…→DIGITS−1→0.
  - an and seg are registered together on the wrap edge, so the segment value and its digit enable change in the same cycle.
- Scanning runs continuously and independently of the converter. A commit takes effect at the next scan slot; the current slot is not glitched.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, ovf=0, seg=8'h00, an=0.
  - Internal: display register=0, prescaler=0, digit index=DIGITS−1, so the first wrap selects digit 0.
- Load sampled at edge k (busy=0). busy=1 from after edge k through the edge that performs COMMIT.
- CONV occupies edges k+1..k+DATA_W. COMMIT occurs at edge k+DATA_W+1, where display, ovf and done=1 are registered.
- busy stays high for DATA_W+1 cycles. A new load is accepted in the cycle after done. Back-to-back loads have a period of DATA_W+2 cycles.
- First lit digit appears SCAN_DIV cycles after reset release: an=1, seg shows digit 0 of the display register (0 → FC).
- When rst=0 during CONV or COMMIT, the conversion is aborted and all state returns to reset values. No partial result is committed and done does not pulse.
- If load and rst=0 arrive in the same cycle, reset wins.

## Configuration
- LEAD_ZERO_BLANK_EN defined:
  - Digit i>0 outputs seg=8'h00 when digits i..DIGITS−1 are all zero.
  - Digit 0 is never blanked.
  - The ovf dash display overrides blanking.
- Undefined: all digits always show their numeral, including leading zeros.

## Test plan
Bench settings: DIGITS=4, DATA_W=14, SCAN_DIV=4.
- Reset, then idle: after 4 cycles an=0001, seg=FC. The scan cycles an 0001→0010→0100→1000→0001 every 4 cycles.
- Load 1234:
  - busy high for 15 cycles, done pulses at cycle 15.
  - Scan then shows digit0=66, digit1=F2, digit2=DA, digit3=60. ovf=0.
- Load 9999, then load 10000:
  - 9999: all digits F6, ovf=0.
  - 10000: ovf=1, all digits 02.
  - Load 16383 also gives ovf=1.
- Load 7 with LEAD_ZERO_BLANK_EN defined: digit0=E0, digits1–3=00. Without the macro, digits1–3=FC.
- Load 5, then pulse load=1 with data=42 three cycles later while busy=1: the second load is ignored and the display shows 5 after done.
- Load 1234, then assert rst=0 at cycle 8 of CONV: done never pulses. After release, the display shows 0 with ovf=0, busy=0 and an=0 until the first wrap.

Source files
------------

// File: rtl/seg7_bcd_scan_if.sv
// Load/result bus between the calculator datapath and the
// 7-segment scan driver.
interface seg7_bcd_scan_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 14
);
    logic              load;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output load, data,
        input  busy, done, ovf, seg, an
    );

    modport slave (
        input  load, data,
        output busy, done, ovf, seg, an
    );
endinterface

// File: rtl/seg7_bcd_scan.sv
// Binary-to-BCD (double-dabble) converter with multiplexed 7-seg scan.
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zero digits.
module seg7_bcd_scan #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    seg7_bcd_scan_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int XW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     disp;
    logic              ovf_acc;
    logic              ovf_q;
    logic              done_q;
    logic [IW-1:0]     iter;

    logic [PW-1:0]     pre;
    logic              wrap;
    logic [XW-1:0]     idx;
    logic [XW-1:0]     idx_nxt;
    logic [3:0]        nib;
    logic              blank;
    logic [7:0]        seg_q;
    logic [7:0]        seg_nxt;
    logic [DIGITS-1:0] an_q;
    logic [DIGITS-1:0] an_nxt;

    function automatic logic [7:0] seg_lut(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Converter state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Converter next-state: IDLE -> CONV (DATA_W steps) -> COMMIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = CONV;
            CONV:    if (iter == IW'(DATA_W - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow on shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Shift engine; a 1 leaving the top nibble means value >= 10^DIGITS
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg   <= '0;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            iter    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg   <= bus.data;
                        bcd     <= '0;
                        ovf_acc <= 1'b0;
                        iter    <= '0;
                    end
                end
                CONV: begin
                    bcd     <= {bcd_adj[BW-2:0], shreg[DATA_W-1]};
                    shreg   <= shreg << 1;
                    ovf_acc <= ovf_acc | bcd_adj[BW-1];
                    iter    <= iter + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Commit result to the display register and pulse done
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp   <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == COMMIT);
            if (state == COMMIT) begin
                disp  <= bcd;
                ovf_q <= ovf_acc;
            end
        end
    end

    // Scan prescaler, wraps every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst)      pre <= '0;
        else if (wrap) pre <= '0;
        else           pre <= pre + PW'(1);
    end

    assign wrap    = (pre == PW'(SCAN_DIV - 1));
    assign idx_nxt = (idx == XW'(DIGITS - 1)) ? '0 : idx + XW'(1);

    // Select the nibble and blanking for the digit about to be shown
    always_comb begin
        logic z;
        nib   = 4'd0;
        blank = 1'b0;
        z     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z = z & (disp[4*i +: 4] == 4'd0);
            if (idx_nxt == XW'(i)) begin
                nib = disp[4*i +: 4];
`ifdef LEAD_ZERO_BLANK_EN
                blank = z && (i > 0);
`else
                blank = 1'b0;
`endif
            end
        end
    end

    // Segment code: dashes on overflow, else blank or numeral
    always_comb begin
        seg_nxt = seg_lut(nib);
        if (ovf_q)      seg_nxt = 8'h02;
        else if (blank) seg_nxt = 8'h00;
        an_nxt = DIGITS'(1) << idx_nxt;
    end

    // Register digit enable and segments together on each wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx   <= XW'(DIGITS - 1);
            an_q  <= '0;
            seg_q <= 8'h00;
        end else if (wrap) begin
            idx   <= idx_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed-vector bench for seg7_bcd_scan.
// Build with LEAD_ZERO_BLANK_EN to check leading-zero blanking.
module tb_seg7_bcd_scan;
    localparam int DIGITS   = 4;
    localparam int DATA_W   = 14;
    localparam int SCAN_DIV = 4;

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'h00;
`else
    localparam logic [7:0] LZ = 8'hFC;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] cap [4];

    always #5 clk = ~clk;

    seg7_bcd_scan_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

    seg7_bcd_scan #(
        .DIGITS  (DIGITS),
        .DATA_W  (DATA_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.load = 1'b0;
        bus.data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic start_load(input logic [DATA_W-1:0] v);
        @(posedge clk); #1;
        bus.load = 1'b1;
        bus.data = v;
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic capture();
        for (int k = 0; k < 4; k++) cap[k] = 8'hxx;
        repeat (16) begin
            @(posedge clk); #1;
            case (bus.an)
                4'b0001: cap[0] = bus.seg;
                4'b0010: cap[1] = bus.seg;
                4'b0100: cap[2] = bus.seg;
                4'b1000: cap[3] = bus.seg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [7:0] es;
        apply_reset();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%b done=%b ovf=%b expected 000",
                     bus.busy, bus.done, bus.ovf);
        end
        vectors++;
        if (bus.seg !== 8'h00 || bus.an !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_scan: seg=%h an=%b expected 00/0000",
                     bus.seg, bus.an);
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                vectors++;
                if (bus.an !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL pre_wrap_an: got %b expected 0000", bus.an);
                end
            end
            if (i % 4 == 0) begin
                ea = 4'b0001 << ((i / 4 - 1) % 4);
                es = (ea == 4'b0001) ? 8'hFC : LZ;
                vectors++;
                if (bus.an !== ea || bus.seg !== es) begin
                    miscompares++;
                    $display("FAIL scan_%0d: an=%b seg=%h expected an=%b seg=%h",
                             i, bus.an, bus.seg, ea, es);
                end
            end
        end
    endtask

    task automatic test_load_1234();
        int busy_cnt = 0;
        int done_at = -1;
        int pulses = 0;
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h66; exp_d[1] = 8'hF2;
        exp_d[2] = 8'hDA; exp_d[3] = 8'h60;
        start_load(14'd1234);
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (busy_cnt != 15) begin
            miscompares++;
            $display("FAIL busy_len: got %0d expected 15", busy_cnt);
        end
        vectors++;
        if (done_at != 15) begin
            miscompares++;
            $display("FAIL done_time: got %0d expected 15", done_at);
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL done_pulses: got %0d expected 1", pulses);
        end
        capture();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (cap[k] !== exp_d[k]) begin
                miscompares++;
                $display("FAIL d1234_%0d: got %h expected %h", k, cap[k], exp_d[k]);
            end
        end
        vectors++;
        if (bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_1234: got %b expected 0", bus.ovf);
        end
    endtask

    task automatic test_overflow();
        bit to;
        logic [13:0] vals [3];
        logic [7:0]  es   [3];
        logic        eo   [3];
        vals[0] = 14'd9999;  es[0] = 8'hF6; eo[0] = 1'b0;
        vals[1] = 14'd10000; es[1] = 8'h02; eo[1] = 1'b1;
        vals[2] = 14'd16383; es[2] = 8'h02; eo[2] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            start_load(vals[v]);
            wait_done(to);
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL done_timeout_%0d: got none expected pulse", vals[v]);
            end
            capture();
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (cap[k] !== es[v]) begin
                    miscompares++;
                    $display("FAIL d%0d_%0d: got %h expected %h",
                             vals[v], k, cap[k], es[v]);
                end
            end
            vectors++;
            if (bus.ovf !== eo[v]) begin
                miscompares++;
                $display("FAIL ovf_%0d: got %b expected %b", vals[v], bus.ovf, eo[v]);
            end
        end
    endtask

    task automatic test_lead_zero();
        bit to;
        start_load(14'd7);
        wait_done(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL done_timeout_7: got none expected pulse");
        end
        capture();
        vectors++;
        if (cap[0] !== 8'hE0) begin
            miscompares++;
            $display("FAIL d7_0: got %h expected e0", cap[0]);
        end
        for (int k = 1; k < 4; k++) begin
            vectors++;
            if (cap[k] !== LZ) begin
                miscompares++;
                $display("FAIL d7_%0d: got %h expected %h", k, cap[k], LZ);
            end
        end
        vectors++;
        if (bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_7: got %b expected 0", bus.ovf);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int extra = 0;
        start_load(14'd5);
        repeat (2) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid: got %b expected 1", bus.busy);
        end
        bus.load = 1'b1;
        bus.data = 14'd42;
        @(posedge clk); #1;
        bus.load = 1'b0;
        wait_done(to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL done_timeout_5: got none expected pulse");
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL queued_load: got %0d busy cycles expected 0", extra);
        end
        capture();
        vectors++;
        if (cap[0] !== 8'hB6) begin
            miscompares++;
            $display("FAIL d5_0: got %h expected b6", cap[0]);
        end
        for (int k = 1; k < 4; k++) begin
            vectors++;
            if (cap[k] !== LZ) begin
                miscompares++;
                $display("FAIL d5_%0d: got %h expected %h", k, cap[k], LZ);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        start_load(14'd1234);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        rst = 1'b1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.ovf !== 1'b0 || bus.an !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b ovf=%b an=%b expected 0/0/0000",
                     bus.busy, bus.ovf, bus.an);
        end
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
            if (i == 3) begin
                vectors++;
                if (bus.an !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL abort_an: got %b expected 0000", bus.an);
                end
            end
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d pulses expected 0", dones);
        end
        capture();
        vectors++;
        if (cap[0] !== 8'hFC) begin
            miscompares++;
            $display("FAIL abort_d0: got %h expected fc", cap[0]);
        end
        for (int k = 1; k < 4; k++) begin
            vectors++;
            if (cap[k] !== LZ) begin
                miscompares++;
                $display("FAIL abort_d%0d: got %h expected %h", k, cap[k], LZ);
            end
        end
        vectors++;
        if (bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_flags: ovf=%b busy=%b expected 0/0",
                     bus.ovf, bus.busy);
        end
    endtask

    initial begin
        bus.load = 1'b0;
        bus.data = '0;
        test_reset();
        test_load_1234();
        test_overflow();
        test_lead_zero();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
